// File: rtl/siren_gen_if.sv
// siren_gen_if: control/status bundle for the siren tone generator.
//   EN, MODE            : enable and mode select (driven by the controller)
//   SPEAKER             : square-wave speaker drive
//   ACTIVE              : tone being generated
//   HALF_PERIOD [HPW]   : current half-period in clock cycles
//   USBPU               : USB pull-up, tied low by the generator
// HPW must match the HPW parameter of the siren_gen instance it connects to.
interface siren_gen_if #(
  parameter int HPW = 16
);
  logic           EN;
  logic [1:0]     MODE;
  logic           SPEAKER;
  logic           ACTIVE;
  logic [HPW-1:0] HALF_PERIOD;
  logic           USBPU;

  modport master (output EN, MODE, input SPEAKER, ACTIVE, HALF_PERIOD, USBPU);
  modport slave  (input EN, MODE, output SPEAKER, ACTIVE, HALF_PERIOD, USBPU);
endinterface

// File: rtl/siren_gen.sv
// siren_gen: multi-mode siren tone generator on one square-wave pin.
//   MODE 0 off, 1 hi-lo alternation, 2 wail (slow sweep), 3 yelp (fast sweep).
// Ports:
//   CLK  system clock
//   RST  asynchronous active-high reset
//   bus  siren_gen_if.slave: EN, MODE in; SPEAKER, ACTIVE, HALF_PERIOD, USBPU out
// Build option: define SIREN_YELP_EN to make mode 3 sweep at SWEEP_CYC>>2;
// otherwise mode 3 behaves as wail (a 2<->3 change still restarts the tone).
module siren_gen #(
  parameter int CLK_HZ     = 16000000,
  parameter int HPW        = 16,
  parameter int HP_LO      = 18181,
  parameter int HP_HI      = 9090,
  parameter int PHASE_CYC  = 8388608,
  parameter int SWEEP_CYC  = 3520,
  parameter int SWEEP_STEP = 1
) (
  input logic       CLK,
  input logic       RST,
  siren_gen_if.slave bus
);
  localparam int PW  = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam int SWW = $clog2(SWEEP_CYC);

  localparam logic [HPW-1:0] LO      = HPW'(HP_LO);
  localparam logic [HPW-1:0] HI      = HPW'(HP_HI);
  localparam logic [HPW:0]   LO_X    = (HPW+1)'(HP_LO);
  localparam logic [HPW:0]   HI_X    = (HPW+1)'(HP_HI);
  localparam logic [HPW:0]   STEP_X  = (HPW+1)'(SWEEP_STEP);
  localparam logic [PW-1:0]  PH_LAST = PW'(PHASE_CYC - 1);
  localparam logic [SWW-1:0] SW_LAST = SWW'(SWEEP_CYC - 1);
`ifdef SIREN_YELP_EN
  localparam logic [SWW-1:0] YL_LAST = SWW'((SWEEP_CYC >> 2) - 1);
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t         st, st_d;
  logic [1:0]     mode_q, mode_d;
  logic [HPW-1:0] hp, hp_d, tcnt, tcnt_d;
  logic [PW-1:0]  ph, ph_d;
  logic [SWW-1:0] sw, sw_d, sw_last;
  logic           dn, dn_d;      // 1: hp rising (pitch falling), 0: hp falling
  logic           spk, spk_d;
  logic           go;
  logic [HPW:0]   hp_sub, hp_add;

  assign go     = bus.EN && (bus.MODE != 2'd0);
  // One guard bit so hp - step can never wrap into a large value.
  assign hp_sub = {1'b0, hp} - STEP_X;
  assign hp_add = {1'b0, hp} + STEP_X;

`ifdef SIREN_YELP_EN
  assign sw_last = (mode_q == 2'd3) ? YL_LAST : SW_LAST;
`else
  assign sw_last = SW_LAST;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st     <= IDLE;
      mode_q <= 2'd0;
      hp     <= LO;
      tcnt   <= '0;
      ph     <= '0;
      sw     <= '0;
      dn     <= 1'b0;
      spk    <= 1'b0;
    end else begin
      st     <= st_d;
      mode_q <= mode_d;
      hp     <= hp_d;
      tcnt   <= tcnt_d;
      ph     <= ph_d;
      sw     <= sw_d;
      dn     <= dn_d;
      spk    <= spk_d;
    end
  end

  always_comb begin
    st_d   = st;
    mode_d = mode_q;
    hp_d   = hp;
    tcnt_d = tcnt;
    ph_d   = ph;
    sw_d   = sw;
    dn_d   = dn;
    spk_d  = spk;
    if (!go) begin
      st_d   = IDLE;
      mode_d = 2'd0;
      hp_d   = LO;
      tcnt_d = '0;
      ph_d   = '0;
      sw_d   = '0;
      dn_d   = 1'b0;
      spk_d  = 1'b0;
    end else if (st == IDLE || bus.MODE != mode_q) begin
      // Restart: entering active, or switching between nonzero modes.
      st_d   = RUN;
      mode_d = bus.MODE;
      hp_d   = LO;
      tcnt_d = LO - HPW'(1);
      ph_d   = '0;
      sw_d   = '0;
      dn_d   = 1'b0;
      spk_d  = 1'b0;
    end else begin
      // Reload reads the registered hp, so a same-edge pitch step only
      // affects the following half-period.
      if (tcnt == '0) begin
        spk_d  = ~spk;
        tcnt_d = hp - HPW'(1);
      end else begin
        tcnt_d = tcnt - HPW'(1);
      end
      if (mode_q == 2'd1) begin
        if (ph == PH_LAST) begin
          ph_d = '0;
          hp_d = (hp == LO) ? HI : LO;
        end else begin
          ph_d = ph + PW'(1);
        end
      end else begin
        if (sw == sw_last) begin
          sw_d = '0;
          if (!dn) begin
            if (hp_sub[HPW] || hp_sub <= HI_X) begin
              hp_d = HI;
              dn_d = 1'b1;
            end else begin
              hp_d = hp_sub[HPW-1:0];
            end
          end else begin
            if (hp_add >= LO_X) begin
              hp_d = LO;
              dn_d = 1'b0;
            end else begin
              hp_d = hp_add[HPW-1:0];
            end
          end
        end else begin
          sw_d = sw + SWW'(1);
        end
      end
    end
  end

  assign bus.SPEAKER     = spk;
  assign bus.ACTIVE      = (st == RUN);
  assign bus.HALF_PERIOD = hp;
  assign bus.USBPU       = 1'b0;
endmodule

// File: tb/tb_siren_gen.sv
module tb_siren_gen;
`ifdef SIREN_YELP_EN
  localparam bit YELP = 1'b1;
`else
  localparam bit YELP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  siren_gen_if #(.HPW(16)) bus ();

  siren_gen #(
    .CLK_HZ(16000000), .HPW(16), .HP_LO(10), .HP_HI(4),
    .PHASE_CYC(100), .SWEEP_CYC(8), .SWEEP_STEP(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    logic       en;
    logic [1:0] mode;
    int         n;       // edges to advance after applying inputs
    bit         cspk;    // speaker compared only where hand-derived
    logic       spk;
    logic       act;
    int         hp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(logic en, logic [1:0] mode, int n, bit cspk,
                              logic spk, logic act, int hp);
    vec_t v;
    v.en = en; v.mode = mode; v.n = n; v.cspk = cspk;
    v.spk = spk; v.act = act; v.hp = hp;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic run(int n);
    repeat (n) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk_all(string nm, logic spk, logic act, int hp);
    chk({nm, ".spk"}, 32'(bus.SPEAKER), 32'(spk));
    chk({nm, ".act"}, 32'(bus.ACTIVE), 32'(act));
    chk({nm, ".hp"}, 32'(bus.HALF_PERIOD), hp);
    chk({nm, ".usbpu"}, 32'(bus.USBPU), 32'd0);
  endtask

  initial begin
    int bad;
    // Hi-lo from idle: restart edge E0, toggles every 10, hp swaps at E100.
    add(0, 0, 2,   1, 0, 0, 10);
    add(1, 1, 1,   1, 0, 1, 10);  // E0
    add(1, 1, 9,   1, 0, 1, 10);  // E9
    add(1, 1, 1,   1, 1, 1, 10);  // E10 first toggle
    add(1, 1, 9,   1, 1, 1, 10);  // E19
    add(1, 1, 1,   1, 0, 1, 10);  // E20
    add(1, 1, 79,  1, 1, 1, 10);  // E99
    add(1, 1, 1,   1, 0, 1, 4);   // E100 wrap + reload with old hp
    add(1, 1, 9,   1, 0, 1, 4);   // E109
    add(1, 1, 1,   1, 1, 1, 4);   // E110
    add(1, 1, 3,   1, 1, 1, 4);   // E113
    add(1, 1, 1,   1, 0, 1, 4);   // E114 spacing now 4
    add(1, 1, 4,   1, 1, 1, 4);   // E118
    // Wail: 10,8,6,4,6,8,10,8 every 8 edges.
    add(1, 2, 1,   1, 0, 1, 10);  // W0 restart
    add(1, 2, 7,   1, 0, 1, 10);
    add(1, 2, 1,   1, 0, 1, 8);
    add(1, 2, 8,   1, 1, 1, 6);   // W16
    add(1, 2, 8,   1, 1, 1, 4);   // W24
    add(1, 2, 8,   0, 0, 1, 6);
    add(1, 2, 8,   0, 0, 1, 8);
    add(1, 2, 8,   0, 0, 1, 10);
    add(1, 2, 8,   0, 0, 1, 8);
    // Yelp: 2-edge interval when enabled, wail timing otherwise.
    add(1, 3, 1,   1, 0, 1, 10);  // Y0 restart
    add(1, 3, 1,   1, 0, 1, 10);
    add(1, 3, 1,   1, 0, 1, YELP ? 8 : 10);
    add(1, 3, 4,   1, 0, 1, YELP ? 4 : 10);
    add(1, 3, 2,   1, 0, 1, YELP ? 6 : 8);
    add(0, 3, 1,   1, 0, 0, 10);
    add(1, 0, 2,   1, 0, 0, 10);

    RST = 1'b1; bus.EN = 1'b0; bus.MODE = 2'd0;
    #2;
    chk_all("reset_init", 0, 0, 10);
    @(negedge CLK);
    RST = 1'b0;

    foreach (vecs[i]) begin
      bus.EN = vecs[i].en;
      bus.MODE = vecs[i].mode;
      run(vecs[i].n);
      if (vecs[i].cspk) chk($sformatf("v%0d.spk", i), 32'(bus.SPEAKER), 32'(vecs[i].spk));
      chk($sformatf("v%0d.act", i), 32'(bus.ACTIVE), 32'(vecs[i].act));
      chk($sformatf("v%0d.hp", i), 32'(bus.HALF_PERIOD), vecs[i].hp);
      chk($sformatf("v%0d.usbpu", i), 32'(bus.USBPU), 32'd0);
    end

    // Async reset mid-tone while hp=4 and SPEAKER=1.
    bus.EN = 1'b1; bus.MODE = 2'd1;
    run(1);
    run(111);
    chk_all("pre_rst", 1, 1, 4);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 chk_all("async_rst", 0, 0, 10);
    @(negedge CLK);
    RST = 1'b0;
    run(1);
    chk_all("rst_restart", 0, 1, 10);
    run(9);
    chk_all("rst_pre_tog", 0, 1, 10);
    run(1);
    chk_all("rst_tog", 1, 1, 10);

    // Mode change mid-sweep (hp=6) back to hi-lo.
    bus.MODE = 2'd2;
    run(1);
    run(16);
    chk_all("sweep_w16", 1, 1, 6);
    bus.MODE = 2'd1;
    run(1);
    chk_all("mchg_restart", 0, 1, 10);
    run(9);
    chk_all("mchg_pre_tog", 0, 1, 10);
    run(1);
    chk_all("mchg_tog", 1, 1, 10);

    // Disable while SPEAKER=1.
    bus.MODE = 2'd2;
    run(17);
    chk_all("dis_pre", 1, 1, 6);
    bus.EN = 1'b0;
    run(1);
    chk_all("dis", 0, 0, 10);
    run(3);
    chk_all("dis_hold", 0, 0, 10);

    // Long wail run: hp stays within [HP_HI, HP_LO].
    bad = 0;
    bus.EN = 1'b1; bus.MODE = 2'd2;
    for (int c = 0; c < 200; c++) begin
      run(1);
      if (bus.HALF_PERIOD < 4 || bus.HALF_PERIOD > 10 || bus.USBPU !== 1'b0) bad++;
    end
    chk("wail_range", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
